// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags (value / busy / producer ROB id).
// Define RF_COMMIT_BYPASS_EN to let source reads see a same-cycle matching commit.
module rename_reg_file #(
   parameter int REG_NUM  = 32,
   parameter int DATA_W   = 32,
   parameter int ROB_ID_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                ID_rename_valid,
   input  logic [4:0]          ID_rd,
   input  logic [ROB_ID_W-1:0] ID_ROB_id,
   input  logic [4:0]          ID_rs1,
   input  logic [4:0]          ID_rs2,
   output logic                ID_rs1_busy,
   output logic [DATA_W-1:0]   ID_rs1_value,
   output logic [ROB_ID_W-1:0] ID_rs1_ROB_id,
   output logic                ID_rs2_busy,
   output logic [DATA_W-1:0]   ID_rs2_value,
   output logic [ROB_ID_W-1:0] ID_rs2_ROB_id,
   input  logic                ROB_commit_valid,
   input  logic [4:0]          ROB_commit_rd,
   input  logic [ROB_ID_W-1:0] ROB_commit_ROB_id,
   input  logic [DATA_W-1:0]   ROB_commit_value,
   input  logic                ROB_roll_back_flag
);

   localparam int IDX_W = 5;
   localparam int SLOTS = 1 << IDX_W;

   // One slot per encodable index; x0 and indices beyond REG_NUM read as constant zero.
   logic                slot_busy  [SLOTS];
   logic [DATA_W-1:0]   slot_value [SLOTS];
   logic [ROB_ID_W-1:0] slot_tag   [SLOTS];
`ifdef RF_COMMIT_BYPASS_EN
   logic                slot_bypass [SLOTS];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_reg
         if (gi == 0 || gi >= REG_NUM) begin : g_zero
            assign slot_busy[gi]  = 1'b0;
            assign slot_value[gi] = '0;
            assign slot_tag[gi]   = '0;
`ifdef RF_COMMIT_BYPASS_EN
            assign slot_bypass[gi] = 1'b0;
`endif
         end else begin : g_live
            logic                busy_reg;
            logic [DATA_W-1:0]   value_reg;
            logic [ROB_ID_W-1:0] tag_reg;
            logic                commit_hit;
            logic                rename_hit;
            logic                clear_hit;

            assign commit_hit = ROB_commit_valid && (ROB_commit_rd == IDX_W'(gi));
            assign rename_hit = ID_rename_valid && (ID_rd == IDX_W'(gi));
            // Only the producer the register currently waits on may release it.
            assign clear_hit  = commit_hit && (tag_reg == ROB_commit_ROB_id);

            always_ff @(posedge clk) begin
               if (rst) begin
                  busy_reg  <= 1'b0;
                  value_reg <= '0;
                  tag_reg   <= '0;
               end else if (rdy) begin
                  if (commit_hit) begin
                     value_reg <= ROB_commit_value;
                  end
                  if (ROB_roll_back_flag) begin
                     busy_reg <= 1'b0;
                     tag_reg  <= '0;
                  end else if (rename_hit) begin
                     busy_reg <= 1'b1;
                     tag_reg  <= ID_ROB_id;
                  end else if (clear_hit) begin
                     busy_reg <= 1'b0;
                  end
               end
            end

            assign slot_busy[gi]  = busy_reg;
            assign slot_value[gi] = value_reg;
            assign slot_tag[gi]   = tag_reg;
`ifdef RF_COMMIT_BYPASS_EN
            // Forward only a commit that is actually consumed on this edge.
            assign slot_bypass[gi] = rdy && clear_hit && busy_reg;
`endif
         end
      end
   endgenerate

   logic [IDX_W-1:0]    rd_idx   [2];
   logic                rd_busy  [2];
   logic [DATA_W-1:0]   rd_value [2];
   logic [ROB_ID_W-1:0] rd_tag   [2];

   assign rd_idx[0] = ID_rs1;
   assign rd_idx[1] = ID_rs2;

   // Reads see registered state, so a same-cycle rename never leaks into its own sources.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic                busy_c;
         logic [DATA_W-1:0]   value_c;
         logic [ROB_ID_W-1:0] tag_c;

         always_comb begin
            busy_c  = slot_busy[rd_idx[gi]];
            value_c = slot_value[rd_idx[gi]];
            tag_c   = slot_tag[rd_idx[gi]];
`ifdef RF_COMMIT_BYPASS_EN
            if (slot_bypass[rd_idx[gi]]) begin
               busy_c  = 1'b0;
               value_c = ROB_commit_value;
            end
`endif
         end

         assign rd_busy[gi]  = busy_c;
         assign rd_value[gi] = value_c;
         assign rd_tag[gi]   = tag_c;
      end
   endgenerate

   assign ID_rs1_busy   = rd_busy[0];
   assign ID_rs1_value  = rd_value[0];
   assign ID_rs1_ROB_id = rd_tag[0];
   assign ID_rs2_busy   = rd_busy[1];
   assign ID_rs2_value  = rd_value[1];
   assign ID_rs2_ROB_id = rd_tag[1];

endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Architectural register file with per-register rename tags for the Tomasulo core. It sits between the Decoder (source reads and destination renames), the ReorderBuffer commit port (in-order retirement of results), and the ReorderBuffer roll-back broadcast. It answers each source operand with one of two things: a committed value, or the ROB id of the in-flight producer.

## Interface
- `REG_NUM`, 32: number of architectural registers; x0 is hardwired to zero.
- `DATA_W`, 32: register data width.
- `ROB_ID_W`, 4: ROB id width, matching a 16-entry ROB.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global enable; when low, all state holds.
- `ID_rename_valid`  in  1  Decoder issues an instruction that writes `ID_rd`.
- `ID_rd`  in  5  destination register of the issuing instruction.
- `ID_ROB_id`  in  ROB_ID_W  ROB entry allocated to the issuing instruction.
- `ID_rs1`, `ID_rs2`  in  5  source register indices.
- `ID_rs1_busy`, `ID_rs2_busy`  out  1  source is awaiting an in-flight producer.
- `ID_rs1_value`, `ID_rs2_value`  out  DATA_W  committed value; meaningful when not busy.
- `ID_rs1_ROB_id`, `ID_rs2_ROB_id`  out  ROB_ID_W  producer tag; meaningful when busy.
- `ROB_commit_valid`  in  1  ROB retires a register-writing instruction this cycle.
- `ROB_commit_rd`  in  5  destination of the retiring instruction.
- `ROB_commit_ROB_id`  in  ROB_ID_W  ROB id of the retiring entry.
- `ROB_commit_value`  in  DATA_W  result to write.
- `ROB_roll_back_flag`  in  1  misprediction flush.

## Operation
- State: `values[REG_NUM]`, `busy[REG_NUM]`, `tags[REG_NUM]`.
- Reads are combinational from state, plus the optional bypass (see Configuration).
- Register 0: reads always return value 0, busy 0, ROB id 0. Renames and commits targeting x0 are ignored.
- Commit (valid, rd≠0): `values[rd] <= ROB_commit_value`.
  - `busy[rd]` clears only if `tags[rd] == ROB_commit_ROB_id` and there is no same-cycle rename of `rd`.
  - On a tag mismatch the value is still written, but busy and tag are kept, because a younger producer owns the register.
- Rename (valid, rd≠0, no roll-back): `busy[rd] <= 1`, `tags[rd] <= ID_ROB_id`.
  - Rename overrides the commit busy-clear on the same register.
- Same-cycle read of a register being renamed returns the pre-rename mapping. This is required for instructions such as `addi x5,x5,1`.
- Roll-back: every `busy` clears next cycle and all tags reset to 0.
  - A same-cycle rename is dropped.
  - A same-cycle commit still writes its value, because it is architectural.
- Reset: all `values`, `busy` and `tags` go to 0. After the reset edge, every read output is 0.
- `rdy` low: no state update, including from commit, rename, roll-back and reset-independent paths. Reads remain valid.

## Timing
- Read latency: 0 cycles (combinational).
- Rename or commit sampled on edge N is visible on read outputs after edge N.
- Roll-back sampled on edge N: from cycle N+1 all reads report not busy, and values reflect commits up to and including edge N.
- Priority per register on a single edge: rst > roll-back > rename > commit-clear. The commit value write is independent of this priority except for rst.
- No back-pressure: every valid input is consumed on the edge where it is sampled, provided `rdy` is high.

## Configuration
- `RF_COMMIT_BYPASS_EN` defined: a read of register r ≠ 0 sees the same-cycle commit when two conditions hold:
  - `ROB_commit_valid` is high with `ROB_commit_rd == r`;
  - the register is busy with `tags[r] == ROB_commit_ROB_id`.
  
  In that case the read returns busy 0 and value `ROB_commit_value`, which saves the Decoder one cycle of stall.
- `RF_COMMIT_BYPASS_EN` undefined: reads reflect registered state only, and the committed value appears one cycle later. All other behaviour is identical.

## Test plan
- Reset then read x1..x31: all report busy 0, value 0, ROB id 0. Commit x0 with value 0xDEAD, then read x0: value 0, busy 0.
- Rename x5 to ROB 3, then read x5: busy 1, ROB id 3. Commit x5 with id 3 and value 0x1234: next cycle x5 reads busy 0, value 0x1234.
- Rename x5 to ROB 3, then rename x5 to ROB 7, then commit x5 with id 3 and value 0x11: x5 reads busy 1, ROB id 7, `values[5]` = 0x11. Commit with id 7 and value 0x22: x5 reads busy 0, value 0x22.
- Same edge: commit x6 with id 2 and value 0xAA while renaming x6 to ROB 9, with x6 previously tagged 2. Then x6 reads busy 1, ROB id 9. A same-cycle read of x6 returns the pre-rename state: with bypass, busy 0 and value 0xAA; without bypass, busy 1 and ROB id 2.
- Rename x1, x2 and x3 to ROB 4, 5 and 6, then assert roll-back together with a commit of x1 (id 4, value 0x55) and a rename of x7 to ROB 8. Next cycle all registers read busy 0, x1 reads 0x55, and x7 is not busy.
- Hold `rdy` low while commit, rename and roll-back are asserted: state is unchanged. Raise `rdy`: the updates apply on the first edge where `rdy` is high.
